// File: rtl/fir_mac_sequencer_if.sv
// fir_mac_sequencer_if: sample stream, delay-line/coefficient bus and result stream of the FIR MAC sequencer.
interface fir_mac_sequencer_if #(
  parameter int input_width  = 16,
  parameter int coeff_width  = 16,
  parameter int coeff_size   = 8,
  parameter int output_width = 16
);
  localparam int address_size = $clog2(coeff_size);
  logic in_valid;
  logic in_ready;
  logic signed [input_width-1:0] in_sample;
  logic shift_enable;
  logic signed [input_width-1:0] shift_in;
  logic [address_size-1:0] address;
  logic signed [input_width-1:0] tap_in;
  logic signed [coeff_width-1:0] coeff_in;
  logic out_valid;
  logic out_ready;
  logic signed [output_width-1:0] out_result;
  modport master (
    input  in_valid, in_sample, tap_in, coeff_in, out_ready,
    output in_ready, shift_enable, shift_in, address, out_valid, out_result
  );
  modport slave (
    output in_valid, in_sample, tap_in, coeff_in, out_ready,
    input  in_ready, shift_enable, shift_in, address, out_valid, out_result
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: per accepted sample, shifts it into an external delay line, then runs one
// tap*coeff MAC per cycle over all taps and presents the scaled, saturated sum.
module fir_mac_sequencer #(
  parameter int input_width  = 16,
  parameter int coeff_width  = 16,
  parameter int coeff_size   = 8,
  parameter int output_width = 16,
  parameter int frac_shift   = 15
) (
  input logic clock,
  input logic reset,
  fir_mac_sequencer_if.master bus
);
  localparam int address_size = $clog2(coeff_size);
  localparam int acc_width    = input_width + coeff_width + address_size;
  localparam int prod_width   = input_width + coeff_width;
  typedef enum logic [1:0] {IDLE, SHIFT, MAC, DONE} state_t;
  state_t state, state_next;
  logic signed [input_width-1:0] hold;
  logic signed [prod_width-1:0] prod;
  logic signed [acc_width-1:0] acc, acc_next, scaled;
  logic [acc_width-output_width:0] upper;
  logic signed [output_width-1:0] result, sat;
  logic [address_size-1:0] addr;
  logic last;
  always_comb begin
    prod     = bus.tap_in * bus.coeff_in;
    acc_next = acc + {{address_size{prod[prod_width-1]}}, prod};
    scaled   = acc_next >>> frac_shift;
    upper    = scaled[acc_width-1:output_width-1];
    // all-equal upper bits means the value already fits in output_width
    sat      = (&upper || ~|upper) ? scaled[output_width-1:0]
             : upper[acc_width-output_width] ? {1'b1, {(output_width-1){1'b0}}}
             : {1'b0, {(output_width-1){1'b1}}};
    last     = addr == address_size'(coeff_size - 1);
  end
  always_ff @(posedge clock)
    if (!reset) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = bus.in_valid ? SHIFT : IDLE;
      SHIFT:   state_next = MAC;
      MAC:     state_next = last ? DONE : MAC;
      default: state_next = bus.out_ready ? IDLE : DONE;
    endcase
  end
  always_comb begin
    bus.in_ready     = state == IDLE && reset;
    bus.shift_enable = state == SHIFT;
    bus.shift_in     = hold;
    bus.address      = addr;
    bus.out_valid    = state == DONE;
    bus.out_result   = result;
  end
  always_ff @(posedge clock)
    if (!reset) begin
      hold   <= '0;
      acc    <= '0;
      addr   <= '0;
      result <= '0;
    end else begin
      if (state == IDLE && bus.in_valid) hold <= bus.in_sample;
      if (state == SHIFT) begin
        acc  <= '0;
        addr <= '0;
      end
      if (state == MAC) begin
        acc  <= acc_next;
        addr <= last ? '0 : addr + 1'b1;
      end
      if (state == MAC && last) result <= sat;
    end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed checks of a 4-tap unity-scaled instance and a default 8-tap Q15 instance,
// each driving a behavioural delay line and coefficient table.
module tb_fir_mac_sequencer;
  logic clock = 0, reset = 0, clr = 0;
  int checks = 0, passed = 0;
  fir_mac_sequencer_if #(.coeff_size(4)) ia();
  fir_mac_sequencer_if ib();
  fir_mac_sequencer #(.coeff_size(4), .frac_shift(0)) dut_a (.clock(clock), .reset(reset), .bus(ia.master));
  fir_mac_sequencer dut_b (.clock(clock), .reset(reset), .bus(ib.master));
  logic signed [15:0] dl_a [4], coef_a [4], dl_b [8], coef_b [8];
  always #5 clock = ~clock;
  always_ff @(posedge clock) begin
    if (clr) begin
      for (int i = 0; i < 4; i++) dl_a[i] <= '0;
      for (int i = 0; i < 8; i++) dl_b[i] <= '0;
    end else begin
      if (ia.shift_enable) begin
        dl_a[0] <= ia.shift_in;
        for (int i = 1; i < 4; i++) dl_a[i] <= dl_a[i-1];
      end
      if (ib.shift_enable) begin
        dl_b[0] <= ib.shift_in;
        for (int i = 1; i < 8; i++) dl_b[i] <= dl_b[i-1];
      end
    end
  end
  assign ia.tap_in = dl_a[ia.address];
  assign ia.coeff_in = coef_a[ia.address];
  assign ib.tap_in = dl_b[ib.address];
  assign ib.coeff_in = coef_b[ib.address];
  task automatic clear_dl();
    clr = 1;
    @(negedge clock);
    clr = 0;
  endtask
  task automatic send_a(input logic signed [15:0] s, output logic signed [15:0] r);
    int n = 0;
    r = 'x;
    ia.in_sample = s; ia.in_valid = 1; ia.out_ready = 1;
    while (!ia.in_ready && n < 50) begin @(negedge clock); n++; end
    @(negedge clock);
    ia.in_valid = 0;
    n = 0;
    while (!ia.out_valid && n < 50) begin @(negedge clock); n++; end
    if (ia.out_valid) r = ia.out_result;
    @(negedge clock);
  endtask
  task automatic send_b(input logic signed [15:0] s, output logic signed [15:0] r);
    int n = 0;
    r = 'x;
    ib.in_sample = s; ib.in_valid = 1; ib.out_ready = 1;
    while (!ib.in_ready && n < 50) begin @(negedge clock); n++; end
    @(negedge clock);
    ib.in_valid = 0;
    n = 0;
    while (!ib.out_valid && n < 50) begin @(negedge clock); n++; end
    if (ib.out_valid) r = ib.out_result;
    @(negedge clock);
  endtask
  task automatic test_reset();
    logic [21:0] got;
    reset = 0;
    repeat (2) @(negedge clock);
    got = {ia.in_ready, ia.out_valid, ia.shift_enable, ia.address, ia.out_result};
    checks++;
    if (got !== 22'd0) $display("FAIL reset_a got=%h exp=0", got); else passed++;
    checks++;
    if ({ib.in_ready, ib.out_valid, ib.shift_enable, ib.address, ib.out_result} !== 22'd0)
      $display("FAIL reset_b got=%h exp=0", {ib.in_ready, ib.out_valid, ib.shift_enable, ib.address, ib.out_result});
    else passed++;
    reset = 1;
    #1;
    checks++;
    if (ia.in_ready !== 1'b1) $display("FAIL release_ready got=%b exp=1", ia.in_ready); else passed++;
    @(negedge clock);
  endtask
  task automatic test_moving_sum();
    logic signed [15:0] r;
    logic signed [15:0] exp [4] = '{16'sd1, 16'sd3, 16'sd6, 16'sd10};
    for (int i = 0; i < 4; i++) coef_a[i] = 16'sd1;
    clear_dl();
    for (int i = 0; i < 4; i++) begin
      send_a(16'(i + 1), r);
      checks++;
      if (r !== exp[i]) $display("FAIL moving_sum[%0d] got=%0d exp=%0d", i, r, exp[i]); else passed++;
    end
  endtask
  task automatic test_impulse();
    logic signed [15:0] r;
    logic signed [15:0] c [4] = '{16'sd5, -16'sd3, 16'sd7, 16'sd2};
    for (int i = 0; i < 4; i++) coef_a[i] = c[i];
    clear_dl();
    for (int i = 0; i < 4; i++) begin
      send_a(i == 0 ? 16'sd1 : 16'sd0, r);
      checks++;
      if (r !== c[i]) $display("FAIL impulse[%0d] got=%0d exp=%0d", i, r, c[i]); else passed++;
    end
  endtask
  task automatic test_saturation();
    logic signed [15:0] r;
    for (int i = 0; i < 8; i++) coef_b[i] = 16'sd32767;
    clear_dl();
    send_b(16'sd32767, r);
    checks++;
    if (r !== 16'sd32766) $display("FAIL sat_inrange got=%0d exp=32766", r); else passed++;
    repeat (7) send_b(16'sd32767, r);
    checks++;
    if (r !== 16'sd32767) $display("FAIL sat_pos got=%0d exp=32767", r); else passed++;
    repeat (8) send_b(-16'sd32768, r);
    checks++;
    if (r !== -16'sd32768) $display("FAIL sat_neg got=%0d exp=-32768", r); else passed++;
  endtask
  task automatic test_timing_backpressure();
    logic [4:0] got, exp;
    int n = 0;
    clear_dl();
    ia.in_sample = 16'sd3; ia.in_valid = 1; ia.out_ready = 1;
    checks++;
    if (ia.in_ready !== 1'b1) $display("FAIL pre_accept_ready got=%b exp=1", ia.in_ready); else passed++;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (k == 1) ia.in_sample = 16'sd9;
      got = {ia.shift_enable, ia.out_valid, ia.in_ready, ia.address};
      exp = {k == 1, k == 6, 1'b0, (k >= 2 && k <= 5) ? 2'(k - 2) : 2'd0};
      checks++;
      if (got !== exp) $display("FAIL timing[T+%0d] got=%b exp=%b", k, got, exp); else passed++;
      if (k == 5) ia.out_ready = 0;
    end
    for (int j = 0; j < 5; j++) begin
      @(negedge clock);
      checks++;
      if ({ia.out_valid, ia.in_ready, ia.shift_enable, ia.out_result} !== {3'b100, 16'sd15})
        $display("FAIL hold[%0d] got=%b/%0d exp=100/15", j, {ia.out_valid, ia.in_ready, ia.shift_enable}, ia.out_result);
      else passed++;
    end
    ia.out_ready = 1;
    @(negedge clock);
    checks++;
    if ({ia.out_valid, ia.in_ready} !== 2'b01) $display("FAIL release got=%b exp=01", {ia.out_valid, ia.in_ready}); else passed++;
    @(negedge clock);
    ia.in_valid = 0;
    checks++;
    if ({ia.shift_enable, ia.shift_in} !== {1'b1, 16'sd9})
      $display("FAIL reaccept got=%b/%0d exp=1/9", ia.shift_enable, ia.shift_in);
    else passed++;
    while (!ia.out_valid && n < 50) begin @(negedge clock); n++; end
    checks++;
    if (!ia.out_valid || ia.out_result !== 16'sd36) $display("FAIL second_result got=%0d exp=36", ia.out_result); else passed++;
    @(negedge clock);
  endtask
  task automatic test_back_to_back();
    int idx [$];
    int n = 0;
    ia.in_sample = 16'sd1; ia.in_valid = 1; ia.out_ready = 1;
    for (int c = 0; c < 22; c++) begin
      if (ia.in_ready) idx.push_back(c);
      @(negedge clock);
    end
    ia.in_valid = 0;
    checks++;
    if (idx.size() < 3 || idx[1] - idx[0] != 7 || idx[2] - idx[1] != 7)
      $display("FAIL throughput got=%0d accepts exp=spacing 7", idx.size());
    else passed++;
    while (!ia.in_ready && n < 50) begin @(negedge clock); n++; end
  endtask
  task automatic test_reset_mid_mac();
    logic seen = 0;
    clear_dl();
    ia.in_sample = 16'sd4; ia.in_valid = 1; ia.out_ready = 1;
    @(negedge clock);
    ia.in_valid = 0;
    repeat (3) @(negedge clock);
    checks++;
    if (ia.address !== 2'd2) $display("FAIL third_mac_addr got=%0d exp=2", ia.address); else passed++;
    reset = 0;
    @(negedge clock);
    checks++;
    if ({ia.out_valid, ia.in_ready, ia.shift_enable, ia.address, ia.out_result} !== 21'd0)
      $display("FAIL mid_mac_reset got=%b/%0d exp=0", {ia.out_valid, ia.in_ready, ia.shift_enable, ia.address}, ia.out_result);
    else passed++;
    reset = 1;
    #1;
    checks++;
    if (ia.in_ready !== 1'b1) $display("FAIL mid_mac_release got=%b exp=1", ia.in_ready); else passed++;
    repeat (12) begin
      @(negedge clock);
      if (ia.out_valid) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) $display("FAIL stale_output got=%b exp=0", seen); else passed++;
  endtask
  initial begin
    ia.in_valid = 0; ia.in_sample = 0; ia.out_ready = 0;
    ib.in_valid = 0; ib.in_sample = 0; ib.out_ready = 0;
    for (int i = 0; i < 4; i++) coef_a[i] = 0;
    for (int i = 0; i < 8; i++) coef_b[i] = 0;
    test_reset();
    test_moving_sum();
    test_impulse();
    test_saturation();
    test_timing_backpressure();
    test_back_to_back();
    test_reset_mid_mac();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 SHALL have parameter input_width, default 16, sample and tap width (signed).
REQ-002 SHALL have parameter coeff_width, default 16, coefficient width (signed).
REQ-003 SHALL have parameter coeff_size, default 8, number of taps; minimum 2.
REQ-004 SHALL have parameter output_width, default 16, result width (signed).
REQ-005 SHALL have parameter frac_shift, default 15, arithmetic right shift applied to the accumulator before saturation.
REQ-006 SHALL derive localparam address_size = $clog2(coeff_size) and acc_width = input_width + coeff_width + address_size.
REQ-007 clock  input  1  sole clock; all state changes on the rising edge.
REQ-008 reset  input  1  synchronous, active-low reset.
REQ-009 in_valid  input  1  upstream sample available.
REQ-010 in_ready  output  1  sequencer accepts a sample.
REQ-011 in_sample  input  input_width  signed sample from upstream.
REQ-012 shift_enable  output  1  enable to the delay-line shift register.
REQ-013 shift_in  output  input_width  sample driven into the delay line.
REQ-014 address  output  address_size  tap select to the delay line and coefficient store.
REQ-015 tap_in  input  input_width  signed delay-line tap at address; combinational, same cycle.
REQ-016 coeff_in  input  coeff_width  signed coefficient at address; combinational, same cycle.
REQ-017 out_valid  output  1  filtered result available.
REQ-018 out_ready  input  1  downstream accepts result.
REQ-019 out_result  output  output_width  signed filtered result.

Function
REQ-020 SHALL implement states IDLE, SHIFT, MAC, DONE.
REQ-021 in_ready SHALL be 1 only in IDLE; in IDLE, in_valid=1 SHALL capture in_sample into a holding register and move to SHIFT.
REQ-022 SHIFT SHALL last exactly one cycle; shift_enable=1 and shift_in = held sample; the accumulator SHALL be cleared; the address counter SHALL be set to 0; next state is MAC.
REQ-023 shift_enable SHALL be 0 in every state other than SHIFT.
REQ-024 MAC SHALL last exactly coeff_size cycles with address = 0, 1, ..., coeff_size-1, one step per cycle.
REQ-025 Each MAC cycle SHALL add the full-precision signed product tap_in*coeff_in, sign-extended to acc_width, to the accumulator; no intermediate truncation.
REQ-026 On the last MAC cycle (address = coeff_size-1), out_result SHALL be registered as saturate(acc_next >>> frac_shift) to output_width; next state is DONE.
REQ-027 Saturation SHALL clamp to +(2^(output_width-1))-1 and -(2^(output_width-1)); in-range values SHALL pass unchanged.
REQ-028 In DONE, out_valid=1 and out_result SHALL stay stable until out_ready=1; that cycle SHALL return to IDLE with out_valid=0 on the next cycle.
REQ-029 The address counter SHALL NOT wrap to 0 within MAC; outside MAC, address SHALL hold 0.
REQ-030 Latency: the accept edge (IDLE, in_valid=1) to the first cycle with out_valid=1 SHALL be exactly coeff_size+2 cycles.
REQ-031 Throughput: with out_ready held at 1, one sample SHALL be accepted every coeff_size+3 cycles.
REQ-032 in_valid during SHIFT, MAC or DONE SHALL be ignored; upstream holds the sample until in_ready=1.
REQ-033 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-034 reset=0 at a rising edge SHALL force IDLE, accumulator 0, address 0, holding register 0, out_result 0, out_valid 0, shift_enable 0.
REQ-035 reset SHALL take priority over every state transition, including mid-MAC and DONE; a partially computed result SHALL be discarded and never presented.
REQ-036 in_ready SHALL be 0 while reset=0 and SHALL go to 1 in the first cycle after reset releases.

Verification
REQ-037 coeff_size=4, coeffs all 1, frac_shift=0; feed 1,2,3,4 -> out_result 1,3,6,10.
REQ-038 coeff_size=4, coeffs 5,-3,7,2, frac_shift=0; impulse 1 then three 0s -> out_result 5,-3,7,2.
REQ-039 Defaults, all coeffs 32767, samples all 32767 -> out_result saturates at 32767; samples all -32768 -> out_result -32768.
REQ-040 Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_result stable, in_ready=0, shift_enable=0 throughout; single accept on release.
REQ-041 Assert reset=0 on the third MAC cycle -> next cycle IDLE, out_valid=0, out_result=0, in_ready=1 after release; no stale output.
REQ-042 Accept on edge T -> shift_enable=1 in cycle T+1 only, address 0..coeff_size-1 in T+2..T+coeff_size+1, out_valid=1 first at T+coeff_size+2.
